// File: rtl/uart_rx.sv
// UART receiver, 8N2 LSB-first, mid-bit sampling; each good byte is written into the wFIFO.
// Two-process FSM with a separate datapath register block driven by the FSM's strobes.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int D_WIDTH   = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_done,
    output logic               frame_err,
    output logic               overrun_err,
    input  logic               wfifo_full,
    output logic               wfifo_wr_en,
    output logic [D_WIDTH-1:0] wfifo_wr_data
);

    localparam int CNT_W        = 15;
    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE - 1;
    localparam int BAUD_CNT_MID = BAUD_CNT_MAX / 2;
    localparam int IDX_W        = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MID);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(D_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rx_meta;
    logic               r_rx_s;
    logic               r_rx_s_d;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [D_WIDTH-1:0] r_shift;
    logic               r_stop1_ok;
    logic [D_WIDTH-1:0] r_rx_data;
    logic               r_rx_done;
    logic               r_frame_err;
    logic               r_overrun_err;
    logic               r_wr_en;

    logic w_fall;
    logic w_sample;
    logic w_start_ok;
    logic w_shift;
    logic w_stop1;
    logic w_eval;
    logic w_good;

    // Two-flop synchronizer plus one delay flop for edge detection; idle level is high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    assign w_fall   = r_rx_s_d & ~r_rx_s;
    assign w_sample = (r_baud_cnt == CNT_MID);
    assign w_good   = r_stop1_ok & r_rx_s;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_shift     = 1'b0;
        w_stop1     = 1'b0;
        w_eval      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_sample) begin
                    w_start_ok  = ~r_rx_s;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == BIT_LAST) w_state_nxt = S_STOP1;
                end
            end
            S_STOP1: begin
                if (w_sample) begin
                    w_stop1     = 1'b1;
                    w_state_nxt = S_STOP2;
                end
            end
            S_STOP2: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (w_sample) begin
                    w_eval      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_stop1_ok <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_baud_cnt == CNT_MAX) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (w_start_ok) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_shift) r_shift <= {r_rx_s, r_shift[D_WIDTH-1:1]};
            if (w_stop1) r_stop1_ok <= r_rx_s;
        end
    end

    // Frame evaluation; wfifo_full only matters at the STOP2 sample.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_data     <= '0;
            r_rx_done     <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_wr_en       <= 1'b0;
        end else begin
            r_rx_done     <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_wr_en       <= 1'b0;
            if (w_eval) begin
                if (w_good) begin
                    r_rx_data     <= r_shift;
                    r_rx_done     <= 1'b1;
                    r_overrun_err <= wfifo_full;
                    r_wr_en       <= ~wfifo_full;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign wfifo_wr_data = r_rx_data;
    assign rx_done       = r_rx_done;
    assign frame_err     = r_frame_err;
    assign overrun_err   = r_overrun_err;
    assign wfifo_wr_en   = r_wr_en;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: frame-level reference model feeds a scoreboard queue,
// an independent monitor pops and compares whenever the receiver reports a frame.
module tb_uart_rx;

    localparam int CLK_FREQ  = 100;
    localparam int BAUD_RATE = 10;
    localparam int D_WIDTH   = 8;
    localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;

    logic               sys_clk     = 1'b0;
    logic               sys_rst_n   = 1'b0;
    logic               rx          = 1'b1;
    logic               wfifo_full  = 1'b0;
    logic [D_WIDTH-1:0] rx_data;
    logic               rx_done;
    logic               frame_err;
    logic               overrun_err;
    logic               wfifo_wr_en;
    logic [D_WIDTH-1:0] wfifo_wr_data;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .D_WIDTH  (D_WIDTH)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err),
        .wfifo_full   (wfifo_full),
        .wfifo_wr_en  (wfifo_wr_en),
        .wfifo_wr_data(wfifo_wr_data)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic       done;
        logic       ferr;
        logic       ovr;
        logic       wr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         wr_times[$];
    int         cyc        = 0;
    int         n_cmp      = 0;
    int         n_fail     = 0;
    logic [7:0] model_data = 8'h00;
    logic       prev_wr    = 1'b0;
    exp_t       mon_e;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every reported frame must match the oldest outstanding prediction.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (wfifo_wr_en) begin
                check("wr_en_gap", {31'd0, prev_wr}, 32'd0);
                wr_times.push_back(cyc);
            end
            if (rx_done || frame_err || overrun_err || wfifo_wr_en) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual done=%0b ferr=%0b ovr=%0b wr=%0b required none",
                             rx_done, frame_err, overrun_err, wfifo_wr_en);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rx_done",     {31'd0, rx_done},     {31'd0, mon_e.done});
                    check("frame_err",   {31'd0, frame_err},   {31'd0, mon_e.ferr});
                    check("overrun_err", {31'd0, overrun_err}, {31'd0, mon_e.ovr});
                    check("wfifo_wr_en", {31'd0, wfifo_wr_en}, {31'd0, mon_e.wr});
                    check("rx_data",     {24'd0, rx_data},     {24'd0, mon_e.data});
                    if (mon_e.wr) check("wfifo_wr_data", {24'd0, wfifo_wr_data}, {24'd0, mon_e.data});
                end
            end
        end
        prev_wr = wfifo_wr_en;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CYC) @(negedge sys_clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CYC) @(negedge sys_clk);
    endtask

    // Reference model: a frame is good iff both stop bits are high; a good frame
    // updates the held byte and is either written or dropped as an overrun.
    task automatic send_frame(input logic [7:0] d, input logic s1, input logic s2, input logic full);
        exp_t e;
        logic good;
        good = s1 & s2;
        if (good) model_data = d;
        e.done = good;
        e.ferr = ~good;
        e.ovr  = good & full;
        e.wr   = good & ~full;
        e.data = model_data;
        sb_q.push_back(e);
        wfifo_full = full;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(s1);
        send_bit(s2);
        if (!s2) idle_bits(2);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(negedge sys_clk);
            t++;
        end
        check(name, sb_q.size(), 32'd0);
        repeat (5) @(negedge sys_clk);
    endtask

    initial begin
        int t0;
        int lat;
        logic [7:0] abort_byte;
        logic [7:0] d;
        logic s1, s2, full;

        repeat (3) @(negedge sys_clk);
        check("rst_rx_data",     {24'd0, rx_data},       32'd0);
        check("rst_wr_data",     {24'd0, wfifo_wr_data}, 32'd0);
        check("rst_rx_done",     {31'd0, rx_done},       32'd0);
        check("rst_frame_err",   {31'd0, frame_err},     32'd0);
        check("rst_overrun_err", {31'd0, overrun_err},   32'd0);
        check("rst_wr_en",       {31'd0, wfifo_wr_en},   32'd0);
        sys_rst_n = 1'b1;
        idle_bits(2);

        // Single good frame; also bounds the start-edge to write latency.
        wr_times.delete();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_a5");
        check("writes_a5", wr_times.size(), 32'd1);
        lat = (wr_times.size() > 0) ? wr_times[0] - t0 : 0;
        check("latency_a5_in_100_115", {31'd0, (lat >= 100 && lat <= 115)}, 32'd1);

        // Back-to-back frames with no idle gap.
        idle_bits(1);
        wr_times.delete();
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_b2b");
        check("writes_b2b", wr_times.size(), 32'd2);
        if (wr_times.size() == 2) check("b2b_spacing", wr_times[1] - wr_times[0], 32'd110);

        // Short low glitch must be rejected silently.
        rx = 1'b0;
        repeat (3) @(negedge sys_clk);
        idle_bits(2);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_glitch");

        // Bad second stop bit, then overrun.
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        wait_drain("drain_ferr");
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        wait_drain("drain_ovr");
        wfifo_full = 1'b0;
        idle_bits(1);

        // Reset in the middle of data bit 4 discards the frame.
        abort_byte = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(abort_byte[i]);
        rx = abort_byte[4];
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("mid_reset_rx_data", {24'd0, rx_data}, 32'd0);
        model_data = 8'h00;
        sys_rst_n = 1'b1;
        idle_bits(3);
        wr_times.delete();
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        wait_drain("drain_12");
        check("writes_12", wr_times.size(), 32'd1);

        // Break: line held low through both stop bits.
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        wait_drain("drain_break");

        // Randomized frames with random stop bits, FIFO-full and idle gaps.
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            s1   = ($urandom_range(0, 5) != 0);
            s2   = ($urandom_range(0, 5) != 0);
            full = ($urandom_range(0, 3) == 0);
            send_frame(d, s1, s2, full);
            idle_bits($urandom_range(0, 2));
        end
        wait_drain("drain_random");
        wfifo_full = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
